scramble_move_generator: RTL
============================

Name: scramble_move_generator

Overview:
- Responder to the shuffle/solve state block's scramble request (RandomPlease).
- On a request, produces a finite sequence of pseudo-random puzzle moves (face index + direction) for the puzzle-state datapath, using a valid/ready handshake.
- Signals completion so the game controller can leave the mix state.
- Sits between the shuffle/solve state logic and the puzzle move-application logic.

Parameters:
- NUM_MOVES, 20, number of moves emitted per scramble (legal range 1..255).
- NUM_FACES, 6, number of distinct faces; legal face indices are 0..NUM_FACES-1 (legal range 2..8).
- MOVE_W, 3, width of the face index; must satisfy 2^MOVE_W >= NUM_FACES.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- random_please  input  1  scramble request level from the shuffle/solve state block.
- move_ready  input  1  downstream accepts the current move.
- move_valid  output  1  move_idx/move_dir hold a valid move.
- move_idx  output  MOVE_W  face index of the move.
- move_dir  output  1  0 = clockwise, 1 = counter-clockwise.
- busy  output  1  high from request acceptance until scramble_done.
- scramble_done  output  1  one-cycle pulse after the last move handshake.

Behaviour:
- Reset values (async, while rst_n=0): move_valid=0, move_idx=0, move_dir=0, busy=0, scramble_done=0, LFSR=SEED (or 1 if SEED=0), move counter=0, previous-face register invalid, request edge register=0, state=IDLE.
- LFSR:
  - 16-bit Galois, right shift, tap mask 16'hB400.
  - Update: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every clock in every state, so button timing adds entropy. It never reaches 0.
- Request detection:
  - A rising edge of random_please (registered previous value) starts a scramble only in IDLE.
  - Edges in any other state are ignored. They are not queued.
  - Deasserting random_please mid-scramble has no effect; the scramble runs to completion.
- States:
  - IDLE: busy=0. On a request edge, go to GEN, set busy=1, clear the counter, invalidate the previous face.
  - GEN: candidate = lfsr[MOVE_W-1:0]. Reject the candidate (stay in GEN, retry next cycle) if candidate >= NUM_FACES, or if it equals the previous face while that face is valid. Otherwise latch move_idx=candidate and move_dir=lfsr[15], then go to EMIT. No modulo arithmetic is used.
  - EMIT: move_valid=1. move_idx and move_dir stay stable until move_valid & move_ready is seen at a rising edge. On that handshake: move_valid=0, previous face=move_idx, counter+1. If the counter was NUM_MOVES-1, go to DONE, otherwise go to GEN.
  - DONE: scramble_done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
- Latency:
  - Request edge to first move_valid is at least 2 cycles (1 cycle into GEN plus at least 1 GEN cycle). Each rejection adds one cycle.
  - With move_ready held at 1, there is at least a 2-cycle interval between handshakes.
- Invariants:
  - move_valid is never high outside EMIT.
  - Consecutive emitted moves never share a face index.
  - Exactly NUM_MOVES handshakes occur per scramble.
- The counter is 8 bits. It never wraps because NUM_MOVES <= 255.
- A reset asserted mid-scramble aborts immediately with no done pulse. After rst_n deasserts the block is in IDLE and needs a new request edge.

Test Plan:
- Reset, random_please 0→1, move_ready held 1 → exactly 20 move_valid&move_ready handshakes, then one scramble_done pulse, busy 1→0 on the cycle after the pulse.
- Same run, monitor every handshake → all move_idx in 0..5 and no two consecutive move_idx equal.
- move_ready held 0 for 10 cycles during EMIT → move_valid stays 1 with move_idx/move_dir constant; a single cycle of move_ready=1 → counter advances by exactly one.
- Toggle random_please 0→1→0→1 while busy → still exactly 20 moves and one done pulse; no second scramble starts.
- rst_n pulled low after the 7th handshake → all outputs 0 asynchronously, no done pulse. A new request edge after release → a full 20-move scramble.
- NUM_FACES=5, MOVE_W=3, NUM_MOVES=1 → exactly one move with idx 0..4, then scramble_done; LFSR values 5..7 in GEN are observed to cause retry cycles.

Source files
------------

// File: rtl/scramble_move_generator.sv
// -----------------------------------------------------------------------------
// scramble_move_generator
//
// Answers the shuffle/solve block's scramble request (random_please). Each
// request produces NUM_MOVES pseudo-random moves (face index plus direction)
// over a valid/ready handshake. It then pulses scramble_done so the game
// controller can leave its mix state.
//
// A free-running 16-bit Galois LFSR supplies the randomness. It advances on
// every clock in every state, so the moment the player presses the button
// changes which moves are drawn.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   random_please in   scramble request level (a rising edge starts a scramble)
//   move_ready    in   downstream accepts the current move
//   move_valid    out  move_idx/move_dir hold a valid move
//   move_idx      out  face index of the move (0..NUM_FACES-1)
//   move_dir      out  0 = clockwise, 1 = counter-clockwise
//   busy          out  high from request acceptance until scramble_done
//   scramble_done out  one-cycle pulse after the last move handshake
// -----------------------------------------------------------------------------
module scramble_move_generator #(
  parameter int unsigned NUM_MOVES = 20,
  parameter int unsigned NUM_FACES = 6,
  parameter int unsigned MOVE_W    = 3,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              random_please,
  input  logic              move_ready,
  output logic              move_valid,
  output logic [MOVE_W-1:0] move_idx,
  output logic              move_dir,
  output logic              busy,
  output logic              scramble_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAP_MASK  = 16'hB400;
  // The extra top bit lets NUM_FACES == 2^MOVE_W be represented exactly.
  localparam logic [MOVE_W:0] FACES_LIM = NUM_FACES[MOVE_W:0];
  localparam logic [7:0]      LAST_CNT  = NUM_MOVES[7:0] - 8'd1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAP_MASK : 16'h0000);
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              req_prev_q, req_prev_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [MOVE_W-1:0] prev_idx_q, prev_idx_d;
  logic              prev_valid_q, prev_valid_d;
  logic              move_valid_q, move_valid_d;
  logic [MOVE_W-1:0] move_idx_q, move_idx_d;
  logic              move_dir_q, move_dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              req_edge_s;
  logic [MOVE_W-1:0] cand_s;
  logic              cand_ok_s;

  assign req_edge_s = random_please & ~req_prev_q;
  assign cand_s     = lfsr_q[MOVE_W-1:0];
  // Out-of-range candidates and repeats of the previous face are retried
  // on the next cycle rather than folded with a modulo. This keeps the
  // face distribution free of modulo bias.
  assign cand_ok_s  = ({1'b0, cand_s} < FACES_LIM) &&
                      !(prev_valid_q && (cand_s == prev_idx_q));

  // Next-state and next-output logic for the scramble sequencer.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_next(lfsr_q);
    req_prev_d   = random_please;
    cnt_d        = cnt_q;
    prev_idx_d   = prev_idx_q;
    prev_valid_d = prev_valid_q;
    move_valid_d = move_valid_q;
    move_idx_d   = move_idx_q;
    move_dir_d   = move_dir_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (req_edge_s) begin
          state_d      = ST_GEN;
          busy_d       = 1'b1;
          cnt_d        = 8'd0;
          prev_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (cand_ok_s) begin
          move_idx_d   = cand_s;
          move_dir_d   = lfsr_q[15];
          move_valid_d = 1'b1;
          state_d      = ST_EMIT;
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_EMIT: begin
        if (move_ready) begin
          move_valid_d = 1'b0;
          prev_idx_d   = move_idx_q;
          prev_valid_d = 1'b1;
          cnt_d        = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GEN;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        move_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State, LFSR and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_INIT;
      req_prev_q   <= 1'b0;
      cnt_q        <= 8'd0;
      prev_idx_q   <= '0;
      prev_valid_q <= 1'b0;
      move_valid_q <= 1'b0;
      move_idx_q   <= '0;
      move_dir_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      req_prev_q   <= req_prev_d;
      cnt_q        <= cnt_d;
      prev_idx_q   <= prev_idx_d;
      prev_valid_q <= prev_valid_d;
      move_valid_q <= move_valid_d;
      move_idx_q   <= move_idx_d;
      move_dir_q   <= move_dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign move_valid    = move_valid_q;
  assign move_idx      = move_idx_q;
  assign move_dir      = move_dir_q;
  assign busy          = busy_q;
  assign scramble_done = done_q;

endmodule
